// File: rtl/alu_multicycle_if.sv
// Handshake/data bundle between a requester and the multicycle ALU.
// master drives requests and consumes results; slave is the ALU side.
interface alu_multicycle_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      IN_VALID;
    logic                      IN_READY;
    logic [DATA_WIDTH-1:0]     A;
    logic [DATA_WIDTH-1:0]     B;
    logic [3:0]                ALU_FUNC;
    logic                      OUT_VALID;
    logic                      OUT_READY;
    logic [2*DATA_WIDTH-1:0]   RESULT;
    logic [3:0]                FLAGS;

    modport master (
        output IN_VALID, A, B, ALU_FUNC, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, FLAGS
    );

    modport slave (
        input  IN_VALID, A, B, ALU_FUNC, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, FLAGS
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle signed ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish one cycle after acceptance; DIV (B != 0) runs a
// restoring division on magnitudes, one quotient bit per cycle.
//
// state  | meaning
// IDLE   | no operation held, ready for a request
// DIV    | iterating the division, W cycles
// DONE   | RESULT/FLAGS valid, waiting for the consumer
module alu_multicycle #(
    parameter int DATA_WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    alu_multicycle_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    quo_q, dvs_q, rem_q;
    logic            q_neg_q, r_neg_q, ovf_div_q;
    logic [2*W-1:0]  result_q;
    logic [3:0]      flags_q;
    logic            out_valid_q;

    logic            in_ready, in_fire, out_fire;
    logic signed [2*W-1:0] ax, bx;
    logic [2*W-1:0]  alu_res_d;
    logic            alu_ovf_d, alu_div0_d;
    logic            div_start;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      shift;
    logic            ge;
    logic [W-1:0]    rem_d, quo_d, q_fin, r_fin;
    logic [2*W-1:0]  div_res;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && bus.OUT_READY);
    assign in_fire   = bus.IN_VALID && in_ready;
    assign out_fire  = out_valid_q && bus.OUT_READY;

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.RESULT    = result_q;
    assign bus.FLAGS     = flags_q;

    assign ax = {{W{bus.A[W-1]}}, bus.A};
    assign bx = {{W{bus.B[W-1]}}, bus.B};

    // True when a 2W-bit signed value is representable in W signed bits.
    function automatic logic fits_w(input logic [2*W-1:0] v);
        return v[2*W-1:W-1] == {(W+1){v[W-1]}};
    endfunction

    // Single-cycle result for every op; DIV with B != 0 is handled by the iterator.
    always_comb begin
        alu_res_d  = '0;
        alu_ovf_d  = 1'b0;
        alu_div0_d = 1'b0;
        case (bus.ALU_FUNC)
            4'h0: begin alu_res_d = ax + bx; alu_ovf_d = !fits_w(alu_res_d); end
            4'h1: begin alu_res_d = ax - bx; alu_ovf_d = !fits_w(alu_res_d); end
            4'h2: begin alu_res_d = ax * bx; alu_ovf_d = !fits_w(alu_res_d); end
            4'h3: begin
                if (bus.B == '0) begin
                    alu_res_d  = {bus.A, {W{1'b1}}};
                    alu_div0_d = 1'b1;
                end
            end
            4'h4: alu_res_d = {{W{1'b0}}, bus.A & bus.B};
            4'h5: alu_res_d = {{W{1'b0}}, bus.A | bus.B};
            4'h6: alu_res_d = {{W{1'b0}}, ~(bus.A & bus.B)};
            4'h7: alu_res_d = {{W{1'b0}}, ~(bus.A | bus.B)};
            4'h9: alu_res_d = {{(2*W-1){1'b0}}, ax == bx};
            4'hA: alu_res_d = {{(2*W-1){1'b0}}, ax > bx};
            4'hB: alu_res_d = {{(2*W-1){1'b0}}, ax < bx};
            4'hC: alu_res_d = {{W{1'b0}}, bus.A[W-1], bus.A[W-1:1]};
            4'hD: alu_res_d = {{W{1'b0}}, bus.A[W-2:0], 1'b0};
            4'hE: alu_res_d = {{W{1'b0}}, 1'b0, bus.B[W-1:1]};
            4'hF: alu_res_d = {{W{1'b0}}, bus.B[W-2:0], 1'b0};
            default: alu_res_d = '0;
        endcase
    end

    assign div_start = (bus.ALU_FUNC == 4'h3) && (bus.B != '0);
    // Negating -2^(W-1) wraps to itself, which is the correct unsigned magnitude.
    assign a_mag = bus.A[W-1] ? -bus.A : bus.A;
    assign b_mag = bus.B[W-1] ? -bus.B : bus.B;

    // One restoring-division step; the partial remainder stays below the divisor,
    // so the shifted value never reaches 2^W.
    always_comb begin
        shift   = {rem_q, quo_q[W-1]};
        ge      = shift >= {1'b0, dvs_q};
        rem_d   = ge ? (shift[W-1:0] - dvs_q) : shift[W-1:0];
        quo_d   = {quo_q[W-2:0], ge};
        q_fin   = q_neg_q ? -quo_d : quo_d;
        r_fin   = r_neg_q ? -rem_d : rem_d;
        div_res = {r_fin, q_fin};
    end

    // Control FSM with registered result, flags and valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ovf_div_q   <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            if (div_start) begin
                state_q     <= S_DIV;
                out_valid_q <= 1'b0;
                cnt_q       <= CW'(W-1);
                quo_q       <= a_mag;
                dvs_q       <= b_mag;
                rem_q       <= '0;
                q_neg_q     <= bus.A[W-1] ^ bus.B[W-1];
                r_neg_q     <= bus.A[W-1];
                ovf_div_q   <= (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == {W{1'b1}});
            end else begin
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
                result_q    <= alu_res_d;
                flags_q     <= {alu_div0_d, alu_ovf_d, alu_res_d[2*W-1], alu_res_d == '0};
            end
        end else begin
            case (state_q)
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= div_res;
                        flags_q     <= {1'b0, ovf_div_q, div_res[2*W-1], div_res == '0};
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_fire) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (W=16): directed vectors with literal expectations,
// then randomized traffic scored against an arithmetic reference model.
module tb_alu_multicycle;
    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    alu_multicycle_if #(.DATA_WIDTH(W)) bus ();

    alu_multicycle #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          rdy;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: {DIV0, OVF, NEG, ZERO, RESULT} from plain signed arithmetic.
    function automatic logic [35:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
        longint sa, sb, r, q, m;
        logic [31:0] res;
        logic ovf, d0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0; ovf = 1'b0; d0 = 1'b0; res = '0;
        case (f)
            4'h0: begin r = sa + sb; ovf = (r > 32767) || (r < -32768); res = r[31:0]; end
            4'h1: begin r = sa - sb; ovf = (r > 32767) || (r < -32768); res = r[31:0]; end
            4'h2: begin r = sa * sb; ovf = (r > 32767) || (r < -32768); res = r[31:0]; end
            4'h3: begin
                if (sb == 0) begin
                    res = {a, 16'hFFFF};
                    d0  = 1'b1;
                end else begin
                    q   = sa / sb;
                    m   = sa % sb;
                    ovf = (q > 32767);
                    res = {m[15:0], q[15:0]};
                end
            end
            4'h4: res = {16'h0, a & b};
            4'h5: res = {16'h0, a | b};
            4'h6: res = {16'h0, ~(a & b)};
            4'h7: res = {16'h0, ~(a | b)};
            4'h8: res = '0;
            4'h9: res = (sa == sb) ? 32'd1 : 32'd0;
            4'hA: res = (sa > sb)  ? 32'd1 : 32'd0;
            4'hB: res = (sa < sb)  ? 32'd1 : 32'd0;
            4'hC: begin r = sa >>> 1; res = {16'h0, r[15:0]}; end
            4'hD: begin r = sa * 2;   res = {16'h0, r[15:0]}; end
            4'hE: res = {16'h0, b / 16'd2};
            default: begin r = longint'(b) * 2; res = {16'h0, r[15:0]}; end
        endcase
        return {d0, ovf, res[31], res == 32'd0, res};
    endfunction

    // Every cycle: compare handshake and data against the scoreboard head.
    always @(negedge CLK) begin : scoreboard
        logic exp_ov, exp_ir;
        logic [35:0] mv;
        exp_t e;
        if (RST) begin
            sb_q.delete();
        end else begin
            exp_ov = 1'b0;
            exp_ir = 1'b1;
            if (sb_q.size() > 0) begin
                if (cyc < sb_q[0].rdy) exp_ir = 1'b0;
                else begin
                    exp_ov = 1'b1;
                    exp_ir = bus.OUT_READY;
                end
            end
            chk("out_valid", 64'(bus.OUT_VALID), 64'(exp_ov));
            chk("in_ready",  64'(bus.IN_READY),  64'(exp_ir));
            if (exp_ov) begin
                chk("sb_result", 64'(bus.RESULT), 64'(sb_q[0].res));
                chk("sb_flags",  64'(bus.FLAGS),  64'(sb_q[0].flg));
                if (bus.OUT_READY) void'(sb_q.pop_front());
            end
            if (bus.IN_VALID && exp_ir) begin
                mv    = model(bus.A, bus.B, bus.ALU_FUNC);
                e.res = mv[31:0];
                e.flg = mv[35:32];
                e.rdy = cyc + ((bus.ALU_FUNC == 4'h3 && bus.B != 16'h0) ? W + 1 : 1);
                sb_q.push_back(e);
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input logic [31:0] er, input logic [3:0] ef, input int elat,
                         input string nm);
        int n, lat;
        logic [35:0] mv;
        mv = model(a, b, f);
        chk({nm, " model_res"}, 64'(mv[31:0]), 64'(er));
        chk({nm, " model_flg"}, 64'(mv[35:32]), 64'(ef));
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b1; bus.A = a; bus.B = b; bus.ALU_FUNC = f; bus.OUT_READY = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!bus.IN_READY && n < 50) begin @(negedge CLK); n++; end
        chk({nm, " accept_timeout"}, 64'(n < 50), 64'd1);
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        bus.A = 16'($urandom); bus.B = 16'($urandom); bus.ALU_FUNC = 4'($urandom);
        lat = 1;
        @(negedge CLK);
        while (!bus.OUT_VALID && lat < 50) begin @(negedge CLK); lat++; end
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " result"},  64'(bus.RESULT), 64'(er));
        chk({nm, " flags"},   64'(bus.FLAGS),  64'(ef));
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_FUNC = '0; bus.OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst result",    64'(bus.RESULT),    64'd0);
        chk("rst flags",     64'(bus.FLAGS),     64'd0);
        @(posedge CLK); #3 RST = 1'b0;
        @(negedge CLK);
        chk("rst in_ready", 64'(bus.IN_READY), 64'd1);

        do_op(16'hFFFA, 16'hFFF9, 4'h0, 32'hFFFFFFF3, 4'b0010, 1, "add_neg");
        do_op(16'h7FFF, 16'h0001, 4'h0, 32'h00008000, 4'b0100, 1, "add_ovf");
        do_op(16'h8000, 16'h0001, 4'h1, 32'hFFFF7FFF, 4'b0110, 1, "sub_ovf");
        do_op(16'hFFFB, 16'h0009, 4'h2, 32'hFFFFFFD3, 4'b0010, 1, "mul_neg");
        do_op(16'h0100, 16'h0100, 4'h2, 32'h00010000, 4'b0100, 1, "mul_ovf");
        do_op(16'h0007, 16'hFFFE, 4'h3, 32'h0001FFFD, 4'b0000, 17, "div_7_m2");
        do_op(16'hFFD3, 16'h0009, 4'h3, 32'h0000FFFB, 4'b0000, 17, "div_m45_9");
        do_op(16'h0005, 16'h0000, 4'h3, 32'h0005FFFF, 4'b1000, 1, "div_by0");
        do_op(16'h8000, 16'hFFFF, 4'h3, 32'h00008000, 4'b0100, 17, "div_ovf");
        do_op(16'h8001, 16'h1234, 4'hC, 32'h0000C000, 4'b0000, 1, "asr_a");
        do_op(16'h1234, 16'h8001, 4'hF, 32'h00000002, 4'b0000, 1, "shl_b");
        do_op(16'hFFFF, 16'h0001, 4'hB, 32'h00000001, 4'b0000, 1, "cmp_lt");
        do_op(16'h1234, 16'h5678, 4'h8, 32'h00000000, 4'b0001, 1, "nop");

        // Backpressure: result must hold while the consumer stalls.
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b1; bus.A = 16'h0009; bus.B = 16'h0003; bus.ALU_FUNC = 4'h4;
        bus.OUT_READY = 1'b0;
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("stall result",   64'(bus.RESULT),    64'h1);
            chk("stall valid",    64'(bus.OUT_VALID), 64'd1);
            chk("stall in_ready", 64'(bus.IN_READY),  64'd0);
            if (k < 2) begin @(posedge CLK); #1; end
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1;
            bus.A = 16'(k + 1); bus.B = 16'(k + 1); bus.ALU_FUNC = 4'h0;
            @(negedge CLK);
            chk("b2b valid", 64'(bus.OUT_VALID), 64'd1);
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b last valid",  64'(bus.OUT_VALID), 64'd1);
        chk("b2b last result", 64'(bus.RESULT),    64'h8);

        // Reset in the middle of a division discards it.
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b1; bus.A = 16'h0007; bus.B = 16'h0003; bus.ALU_FUNC = 4'h3;
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("async rst valid",    64'(bus.OUT_VALID), 64'd0);
        chk("async rst result",   64'(bus.RESULT),    64'd0);
        chk("async rst flags",    64'(bus.FLAGS),     64'd0);
        chk("async rst in_ready", 64'(bus.IN_READY),  64'd1);
        @(posedge CLK); #3 RST = 1'b0;
        @(negedge CLK);
        chk("post rst in_ready", 64'(bus.IN_READY), 64'd1);
        repeat (20) @(negedge CLK);
        chk("post rst no valid", 64'(bus.OUT_VALID), 64'd0);
        do_op(16'h0001, 16'h0001, 4'h0, 32'h00000002, 4'b0000, 1, "add_after_rst");

        // Randomized traffic; the scoreboard does the checking.
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #1;
            bus.IN_VALID  = ($urandom_range(0, 99) < 60);
            bus.OUT_READY = ($urandom_range(0, 99) < 70);
            bus.A         = pick();
            bus.B         = pick();
            bus.ALU_FUNC  = ($urandom_range(0, 3) == 0) ? 4'h3 : 4'($urandom);
        end
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        chk("drain empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width W (legal 4..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port IN_VALID  input  1  request present.
REQ-005 SHALL have port IN_READY  output  1  block accepts request; transfer when IN_VALID && IN_READY.
REQ-006 SHALL have port A  input  W  signed operand A.
REQ-007 SHALL have port B  input  W  signed operand B.
REQ-008 SHALL have port ALU_FUNC  input  4  opcode.
REQ-009 SHALL have port OUT_VALID  output  1  RESULT/FLAGS valid.
REQ-010 SHALL have port OUT_READY  input  1  consumer accepts; transfer when OUT_VALID && OUT_READY.
REQ-011 SHALL have port RESULT  output  2W  registered result.
REQ-012 SHALL have port FLAGS  output  4  registered {DIV0, OVF, NEG, ZERO}, MSB first.

Function
REQ-013 SHALL decode ALU_FUNC: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 NOP, 1001 CMP_EQ, 1010 CMP_GT, 1011 CMP_LT, 1100 A>>>1 (arithmetic), 1101 A<<1, 1110 B>>1 (logical), 1111 B<<1.
REQ-014 SHALL capture A, B, ALU_FUNC on acceptance; later input changes SHALL NOT affect the accepted operation.
REQ-015 SHALL use FSM states IDLE, DIV, DONE; IDLE->DONE on accepting a non-DIV op or DIV with B=0; IDLE->DIV on accepting DIV with B!=0; DIV->DONE after W iterations; DONE->IDLE on output transfer with no new acceptance; DONE->DONE/DIV on output transfer with simultaneous acceptance.
REQ-016 SHALL drive IN_READY = (state==IDLE) || (state==DONE && OUT_READY), combinationally.
REQ-017 SHALL assert OUT_VALID exactly in DONE; non-DIV ops and DIV-by-zero: OUT_VALID rises 1 cycle after acceptance; DIV with B!=0: W+1 cycles after acceptance.
REQ-018 SHALL hold RESULT, FLAGS and OUT_VALID stable while OUT_VALID && !OUT_READY.
REQ-019 ADD/SUB SHALL produce the exact signed sum/difference sign-extended to 2W; OVF=1 when the true result is outside W-bit signed range.
REQ-020 MUL SHALL produce the full signed 2W product; OVF=1 when the product is outside W-bit signed range.
REQ-021 DIV SHALL be an iterative one-bit-per-cycle division on magnitudes; quotient truncated toward zero in RESULT[W-1:0], remainder with dividend sign in RESULT[2W-1:W]; OVF=1 only for A=-2^(W-1), B=-1 (quotient = -2^(W-1), remainder 0).
REQ-022 DIV with B=0 SHALL not iterate: quotient all ones, remainder = A, DIV0=1, OVF=0.
REQ-023 Logic ops and shifts SHALL produce W-bit result zero-extended to 2W; OVF=0; A<<1 and B<<1 discard the MSB.
REQ-024 CMP ops SHALL set RESULT=1 if the signed relation holds, else 0; NOP SHALL set RESULT=0.
REQ-025 ZERO SHALL equal (RESULT==0); NEG SHALL equal RESULT[2W-1]; DIV0 SHALL be 0 for all non-DIV ops.

Reset
REQ-026 RST high SHALL immediately force state IDLE, RESULT=0, FLAGS=0, OUT_VALID=0, iteration counter 0, regardless of clock.
REQ-027 RST asserted during DIV or DONE SHALL discard the operation; no OUT_VALID for it after RST falls.
REQ-028 IN_READY SHALL be 1 from the first cycle after RST deasserts.

Verification (W=16)
REQ-029 ADD A=0xFFFA, B=0xFFF9 -> next cycle OUT_VALID=1, RESULT=0xFFFFFFF3, FLAGS=0b0010; ADD 0x7FFF+0x0001 -> RESULT=0x00008000, FLAGS=0b0100.
REQ-030 MUL 0xFFFB*0x0009 -> RESULT=0xFFFFFFD3, FLAGS=0b0010; MUL 0x0100*0x0100 -> RESULT=0x00010000, FLAGS=0b0100.
REQ-031 DIV 0x0007/0xFFFE -> IN_READY=0 for cycles 1..16, OUT_VALID at cycle 17, RESULT=0x0001FFFD; DIV 0xFFD3/0x0009 -> RESULT=0x0000FFFB.
REQ-032 DIV 0x0005/0x0000 -> OUT_VALID next cycle, RESULT=0x0005FFFF, FLAGS=0b1000; DIV 0x8000/0xFFFF -> RESULT=0x00008000, FLAGS=0b0100.
REQ-033 OUT_READY=0 for 3 cycles after AND 0x0009&0x0003 -> RESULT=0x00000001 stable, IN_READY=0; then OUT_READY=1 with back-to-back IN_VALID -> one result per cycle.
REQ-034 RST pulse at cycle 5 of a DIV -> OUT_VALID=0, RESULT=0 immediately; next accepted ADD 0x0001+0x0001 -> RESULT=0x00000002.
